// File: rtl/mips_irq_pkg.sv
// mips_irq_pkg: shared defaults and FSM state encoding for the interrupt controller.
package mips_irq_pkg;
    localparam int N_SRC_DEF = 8;
    localparam int ID_W_DEF  = 3;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;
endpackage

// File: rtl/mips_irq_prio_enc.sv
// mips_irq_prio_enc: combinational lowest-index priority encoder with any flag.
module mips_irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] in_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);
    always_comb begin
        idx_o = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--)
            if (in_i[i]) idx_o = ID_W'(i);
    end
    assign any_o = |in_i;
endmodule

// File: rtl/mips_irq_controller.sv
// mips_irq_controller: edge-latched, masked, lowest-index interrupt source for the core,
// tracked through a request/ack/end-of-interrupt handshake.
module mips_irq_controller
    import mips_irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_en_we,
    input  logic [N_SRC-1:0] i_en_wdata,
    input  logic             i_ack,
    input  logic             i_eoi,
    input  logic             i_ovr_clr,
    output logic             o_external_interrupt,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [N_SRC-1:0] o_pending,
    output logic [N_SRC-1:0] o_en,
    output logic             o_overrun
);
    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] irq_q, pending_q, pending_d, en_q, en_d, rise, clr, eligible;
    logic [ID_W-1:0]  id_q, id_d, winner;
    logic             ext_q, ext_d, ovr_q, ovr_d, any;
    mips_irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_enc (
        .in_i  (eligible),
        .idx_o (winner),
        .any_o (any)
    );
    assign rise      = i_irq & ~irq_q;
    assign clr       = (state_q == ST_REQ && i_ack) ? (N_SRC'(1) << id_q) : '0;
    // Set after clear: an event landing on its own ack cycle stays pending.
    assign pending_d = (pending_q & ~clr) | rise;
    assign ovr_d     = (|(rise & pending_q & ~clr)) | (ovr_q & ~i_ovr_clr);
    assign en_d      = i_en_we ? i_en_wdata : en_q;
    assign eligible  = pending_q & en_q;
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ext_d   = ext_q;
        case (state_q)
            ST_IDLE: if (any) begin
                id_d    = winner;
                ext_d   = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: if (i_ack) begin
                ext_d   = 1'b0;
                state_d = ST_SERVICE;
            end
            ST_SERVICE: if (i_eoi) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            en_q      <= '1;
            ovr_q     <= 1'b0;
            id_q      <= '0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= i_irq;
            pending_q <= pending_d;
            en_q      <= en_d;
            ovr_q     <= ovr_d;
            id_q      <= id_d;
            ext_q     <= ext_d;
        end
    end
    assign o_external_interrupt = ext_q;
    assign o_irq_id             = id_q;
    assign o_pending            = pending_q;
    assign o_en                 = en_q;
    assign o_overrun            = ovr_q;
endmodule
